// File: rtl/cmp_seq_pkg.sv
// Shared types and defaults for the compare frame sequencer.
//   state_t    : sequencer FSM states (IDLE/CMP/DONE)
//   res_code_t : decoded comparator outcome (GT/EQ/LT/ERR)
package cmp_seq_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_FRAME_LEN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GT  = 2'd0,
        EQ  = 2'd1,
        LT  = 2'd2,
        ERR = 2'd3
    } res_code_t;

endpackage

// File: rtl/compare_frame_sequencer_if.sv
// Operand-in and result-out handshakes of the compare frame sequencer.
//   in_*      : operand pair stream (valid/ready, last marks frame end)
//   res_*     : held frame result (valid/ready)
//   *_cnt     : frame tallies carried with the result
// master = upstream producer / result consumer, slave = sequencer.
interface compare_frame_sequencer_if
    import cmp_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = $clog2(DEF_FRAME_LEN + 1)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;

    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] pair_cnt;

    modport master (
        output in_valid, in_a, in_b, in_last, res_ready,
        input  in_ready, res_valid, gt_cnt, eq_cnt, lt_cnt, pair_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, res_ready,
        output in_ready, res_valid, gt_cnt, eq_cnt, lt_cnt, pair_cnt
    );

endinterface

// File: rtl/cmp_flag_decode.sv
// Maps the comparator's {agb,aeb,alb} flags onto a result code.
//   agb/aeb/alb : raw comparator flags
//   code_c      : combinational result code
// With CMP_FLAG_CHECK_EN defined, anything other than exactly one flag set
// decodes to ERR; otherwise flags are resolved by priority AGB > ALB > AEB
// and an all-zero pattern is treated as equal.
module cmp_flag_decode
    import cmp_seq_pkg::*;
(
    input  logic      agb,
    input  logic      aeb,
    input  logic      alb,
    output res_code_t code_c
);

    always_comb begin
        code_c = EQ;
`ifdef CMP_FLAG_CHECK_EN
        case ({agb, aeb, alb})
            3'b100:  code_c = GT;
            3'b010:  code_c = EQ;
            3'b001:  code_c = LT;
            default: code_c = ERR;
        endcase
`else
        if (agb)      code_c = GT;
        else if (alb) code_c = LT;
        else if (aeb) code_c = EQ;
        else          code_c = EQ;
`endif
    end

endmodule

// File: rtl/compare_frame_sequencer.sv
// Streaming front/back end for an external magnitude comparator.
// Registers each accepted operand pair onto cmp_a/cmp_b, samples the
// comparator flags one cycle later and tallies greater/equal/less per frame.
// A frame closes on in_last or after FRAME_LEN pairs; its tallies are then
// held with res_valid until res_ready.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : operand stream in, frame result out
//   cmp_a, cmp_b    : registered operands to the comparator
//   cmp_agb/aeb/alb : comparator flags
//   flag_err        : sticky illegal-flag indicator
// Optional macro CMP_FLAG_CHECK_EN: non-one-hot flags set flag_err and the
// pair is counted in pair_cnt only; when undefined flag_err stays 0.
module compare_frame_sequencer
    import cmp_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    compare_frame_sequencer_if.slave bus,
    output logic [WIDTH-1:0]         cmp_a,
    output logic [WIDTH-1:0]         cmp_b,
    input  logic                     cmp_agb,
    input  logic                     cmp_aeb,
    input  logic                     cmp_alb,
    output logic                     flag_err
);

    state_t           state;
    logic             in_ready_q;
    logic             res_valid_q;
    logic             last_q;
    logic [CNT_W-1:0] gt_q;
    logic [CNT_W-1:0] eq_q;
    logic [CNT_W-1:0] lt_q;
    logic [CNT_W-1:0] pair_q;

    res_code_t        code_c;
    logic             frame_full_c;

    cmp_flag_decode u_decode (
        .agb    (cmp_agb),
        .aeb    (cmp_aeb),
        .alb    (cmp_alb),
        .code_c (code_c)
    );

    // The pair being tallied this cycle is the last one the frame can hold.
    assign frame_full_c = (pair_q + CNT_W'(1)) == CNT_W'(FRAME_LEN);

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.gt_cnt    = gt_q;
    assign bus.eq_cnt    = eq_q;
    assign bus.lt_cnt    = lt_q;
    assign bus.pair_cnt  = pair_q;

    // Sequencer FSM with registered handshake outputs and tallies.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            last_q      <= 1'b0;
            cmp_a       <= '0;
            cmp_b       <= '0;
            gt_q        <= '0;
            eq_q        <= '0;
            lt_q        <= '0;
            pair_q      <= '0;
            flag_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        cmp_a      <= bus.in_a;
                        cmp_b      <= bus.in_b;
                        last_q     <= bus.in_last;
                        in_ready_q <= 1'b0;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    pair_q <= pair_q + CNT_W'(1);
                    case (code_c)
                        GT:  gt_q <= gt_q + CNT_W'(1);
                        EQ:  eq_q <= eq_q + CNT_W'(1);
                        LT:  lt_q <= lt_q + CNT_W'(1);
                        ERR: begin
`ifdef CMP_FLAG_CHECK_EN
                            flag_err <= 1'b1;
`endif
                        end
                        default: ;
                    endcase
                    // in_last and a full frame together still close once.
                    if (last_q || frame_full_c) begin
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DONE: begin
                    // Reopen only on the next edge; no accept in the release cycle.
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        gt_q        <= '0;
                        eq_q        <= '0;
                        lt_q        <= '0;
                        pair_q      <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    res_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/compare_frame_sequencer.md
Name: compare_frame_sequencer

Overview:
Streaming front/back end for the 8-bit magnitude comparator. Accepts operand pairs over a valid/ready handshake and drives them, registered, onto the comparator's A/B inputs. Captures the returned AGB/AEB/ALB flags and accumulates per-frame greater/equal/less tallies. Presents the tallies as a held result with its own valid/ready handshake.

Parameters:
WIDTH, 8, operand width; must match comparator width
FRAME_LEN, 16, max pairs per frame (>=1); frame closes at FRAME_LEN or on in_last
CNT_W, $clog2(FRAME_LEN+1), width of each tally and of the pair counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_last  input  1  pair is last of frame (qualified by in_valid&&in_ready)
cmp_a  output  WIDTH  registered operand to comparator A
cmp_b  output  WIDTH  registered operand to comparator B
cmp_agb  input  1  comparator A>B flag
cmp_aeb  input  1  comparator A==B flag
cmp_alb  input  1  comparator A<B flag
res_valid  output  1  frame result held
res_ready  input  1  consumer takes result
gt_cnt  output  CNT_W  pairs with A>B in frame
eq_cnt  output  CNT_W  pairs with A==B
lt_cnt  output  CNT_W  pairs with A<B
pair_cnt  output  CNT_W  pairs in frame
flag_err  output  1  sticky illegal-flag indicator (feature-dependent)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, res_valid=0, cmp_a=cmp_b=0, all counts=0, flag_err=0.
- Reset mid-frame or in DONE: drop partial frame and held result; return to reset values next edge.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a/in_b into cmp_a/cmp_b; latch in_last into last_q; go to CMP.
- CMP:
  - in_ready=0; comparator settles combinationally.
  - At end of cycle, sample flags and increment exactly one tally plus pair_cnt.
  - If last_q=1 or pair_cnt+1==FRAME_LEN: go to DONE. Otherwise go to IDLE.
  - Throughput: 1 pair per 2 cycles.
  - Latency: accept edge to tally update = 2 edges.
- DONE:
  - in_ready=0; res_valid=1; counts held stable.
  - On res_ready: clear counts, pair_cnt and res_valid; go to IDLE. No new pair is accepted in the same cycle.
- in_last and the FRAME_LEN limit hitting together: single frame close, no double count.
- cmp_a/cmp_b hold their last value outside IDLE-accept.
- Counter widths: counts never exceed FRAME_LEN, so no wrap is possible. gt_cnt+eq_cnt+lt_cnt==pair_cnt always.
- in_valid while in_ready=0: ignored. Upstream holds its data.

Optional Feature:
Macro CMP_FLAG_CHECK_EN.
- Defined:
  - In CMP, flags not exactly one-hot set flag_err (sticky until rst).
  - That pair still counts in pair_cnt but in no tally. The invariant becomes tally sum <= pair_cnt.
- Undefined:
  - flag_err tied 0.
  - Flags decoded by priority AGB > ALB > AEB. If none are set, the pair counts as equal.

Decomposition:
- Package cmp_seq_pkg holds:
  - state enum typedef (IDLE/CMP/DONE)
  - default WIDTH=8 and FRAME_LEN=16
  - 2-bit result code typedef (GT/EQ/LT/ERR)
- One sub-module, cmp_flag_decode: combinational; maps {agb,aeb,alb} to result code; macro-dependent.
- Counters and FSM stay in the top module.

Test Plan:
- Reset then pairs (0x80,0x7F),(0x12,0x12),(0x00,0xFF) with in_last on third -> res_valid; gt=1, eq=1, lt=1, pair_cnt=3; cmp_a=0x80 one edge after first accept.
- 16 pairs (i,i) without in_last, FRAME_LEN=16 -> DONE after 16th; eq=16, others 0; in_ready low until res_ready.
- Hold res_ready=0 for 5 cycles in DONE with in_valid=1 -> counts stable, no accept; res_ready=1 -> in_ready=1 on next cycle.
- Assert rst during CMP of second pair -> next cycle res_valid=0, counts 0, in_ready=1; subsequent frame counts from zero.
- With CMP_FLAG_CHECK_EN: force agb=aeb=1 on one pair -> flag_err=1 sticky; pair_cnt includes it, tallies exclude it. Without the macro: counts as gt.
- Back-to-back in_valid constantly high -> accepts exactly every other cycle; 4 pairs in_last -> result after 8 cycles.
